// File: rtl/intr_arbiter_if.sv
// Event/interrupt bus between the interrupt arbiter and its environment.
// The slave side is the arbiter; the master side drives events, the mask and the CPU ack.
interface intr_arbiter_if #(
    parameter int unsigned NUM_SRC = 4
) ();
    logic [NUM_SRC-1:0] src;
    logic [NUM_SRC-1:0] mask;
    logic               intr_ack;
    logic               interrupt;
    logic [2:0]         intr_id;
    logic [NUM_SRC-1:0] pending;

    modport master (
        output src, mask, intr_ack,
        input  interrupt, intr_id, pending
    );

    modport slave (
        input  src, mask, intr_ack,
        output interrupt, intr_id, pending
    );
endinterface

// File: rtl/intr_arbiter.sv
// Serializes up to NUM_SRC edge events onto one CPU interrupt line by fixed priority
// (index 0 highest), with an ack timeout and a forced low gap between interrupts.
module intr_arbiter #(
    parameter int unsigned NUM_SRC = 4,
    parameter int unsigned ACK_TMO = 64,
    parameter int unsigned GAP     = 8
) (
    input  logic           clk,
    input  logic           rst,
    intr_arbiter_if.slave  bus
);
    localparam int unsigned ID_W  = 3;
    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ASSERT = 2'd1,
        GAP_ST = 2'd2
    } state_t;

    logic [NUM_SRC-1:0] sync1_q, sync2_q, prev_q;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [NUM_SRC-1:0] rise_c, eligible_c, clr_c;
    logic [ID_W-1:0]    sel_c;
    logic [ID_W-1:0]    intr_id_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               interrupt_q;
    state_t             state_q;

    assign rise_c     = sync2_q & ~prev_q;
    assign eligible_c = pending_q & bus.mask;

    // Lowest eligible index wins; iterate downward so the last hit is the lowest.
    always_comb begin
        sel_c = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (eligible_c[i]) sel_c = ID_W'(i);
        end
    end

    // Ack only clears the source currently being signalled; a same-cycle rise still sets it.
    always_comb begin
        clr_c = '0;
        if (state_q == ASSERT && bus.intr_ack) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (intr_id_q == ID_W'(i)) clr_c[i] = 1'b1;
            end
        end
    end

    assign pending_d = (pending_q & ~clr_c) | rise_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            prev_q    <= '0;
            pending_q <= '0;
        end else begin
            sync1_q   <= bus.src;
            sync2_q   <= sync1_q;
            prev_q    <= sync2_q;
            pending_q <= pending_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            interrupt_q <= 1'b0;
            intr_id_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (eligible_c != '0) begin
                        state_q     <= ASSERT;
                        intr_id_q   <= sel_c;
                        interrupt_q <= 1'b1;
                        cnt_q       <= '0;
                    end else begin
                        interrupt_q <= 1'b0;
                    end
                end
                ASSERT: begin
                    if (bus.intr_ack || cnt_q == CNT_W'(ACK_TMO - 1)) begin
                        state_q     <= GAP_ST;
                        interrupt_q <= 1'b0;
                        cnt_q       <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                GAP_ST: begin
                    interrupt_q <= 1'b0;
                    if (cnt_q == CNT_W'(GAP - 1)) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    interrupt_q <= 1'b0;
                    cnt_q       <= '0;
                end
            endcase
        end
    end

    assign bus.interrupt = interrupt_q;
    assign bus.intr_id   = intr_id_q;
    assign bus.pending   = pending_q;
endmodule

// File: tb/tb_intr_arbiter.sv
// Directed bench for intr_arbiter: a per-cycle vector table plus sequences for timeout and reset.
module tb_intr_arbiter;
    localparam int unsigned NUM_SRC = 4;
    localparam int unsigned ACK_TMO = 64;
    localparam int unsigned GAP     = 8;

    logic clk = 1'b0;
    logic rst;
    int   pass_cnt = 0;
    int   total_cnt = 0;

    always #5 clk = ~clk;

    intr_arbiter_if #(.NUM_SRC(NUM_SRC)) bus ();

    intr_arbiter #(
        .NUM_SRC(NUM_SRC),
        .ACK_TMO(ACK_TMO),
        .GAP    (GAP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic [3:0] src;
        logic [3:0] mask;
        logic       ack;
        logic       exp_int;
        logic [2:0] exp_id;
        logic [3:0] exp_pend;
    } vec_t;

    vec_t vq[$];

    task automatic add_n(input int n, input logic [3:0] s, input logic [3:0] m, input logic a,
                         input logic e, input logic [2:0] id, input logic [3:0] p);
        vec_t v;
        v.src = s; v.mask = m; v.ack = a; v.exp_int = e; v.exp_id = id; v.exp_pend = p;
        for (int i = 0; i < n; i++) vq.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        int m;

        // Vector i: inputs sampled at edge i, outputs checked just after edge i.
        add_n(2, 4'b0100, 4'hF, 0, 0, 0, 4'b0000);
        add_n(1, 4'b0100, 4'hF, 0, 0, 0, 4'b0100);
        add_n(2, 4'b0100, 4'hF, 0, 1, 2, 4'b0100);
        add_n(1, 4'b0000, 4'hF, 1, 0, 0, 4'b0000);
        add_n(8, 4'b0000, 4'hF, 0, 0, 0, 4'b0000);
        add_n(2, 4'b1010, 4'hF, 0, 0, 0, 4'b0000);
        add_n(1, 4'b1010, 4'hF, 0, 0, 0, 4'b1010);
        add_n(2, 4'b1010, 4'hF, 0, 1, 1, 4'b1010);
        add_n(1, 4'b1010, 4'hF, 1, 0, 0, 4'b1000);
        add_n(8, 4'b1010, 4'hF, 0, 0, 0, 4'b1000);
        add_n(1, 4'b1010, 4'hF, 0, 1, 3, 4'b1000);
        add_n(1, 4'b0000, 4'hF, 1, 0, 0, 4'b0000);
        add_n(8, 4'b0000, 4'hF, 0, 0, 0, 4'b0000);
        add_n(2, 4'b0001, 4'hE, 0, 0, 0, 4'b0000);
        add_n(3, 4'b0001, 4'hE, 0, 0, 0, 4'b0001);
        add_n(1, 4'b0001, 4'hF, 0, 1, 0, 4'b0001);
        add_n(1, 4'b0000, 4'hF, 1, 0, 0, 4'b0000);
        add_n(8, 4'b0000, 4'hF, 0, 0, 0, 4'b0000);
        add_n(2, 4'b0100, 4'hF, 0, 0, 0, 4'b0000);
        add_n(1, 4'b0100, 4'hF, 0, 0, 0, 4'b0100);
        add_n(1, 4'b0100, 4'hF, 0, 1, 2, 4'b0100);
        add_n(1, 4'b0000, 4'hF, 0, 1, 2, 4'b0100);
        add_n(2, 4'b0100, 4'hF, 0, 1, 2, 4'b0100);
        add_n(1, 4'b0100, 4'hF, 1, 0, 0, 4'b0100);
        add_n(8, 4'b0100, 4'hF, 0, 0, 0, 4'b0100);
        add_n(4, 4'b0100, 4'hF, 0, 1, 2, 4'b0100);
        add_n(1, 4'b0100, 4'hF, 1, 0, 0, 4'b0000);
        add_n(10, 4'b0100, 4'hF, 0, 0, 0, 4'b0000);

        rst = 1'b1;
        bus.src = '0;
        bus.mask = 4'hF;
        bus.intr_ack = 1'b0;
        #1;
        check("reset_interrupt", 32'(bus.interrupt), 32'd0);
        check("reset_id", 32'(bus.intr_id), 32'd0);
        check("reset_pending", 32'(bus.pending), 32'd0);
        tick();
        rst = 1'b0;

        foreach (vq[i]) begin
            bus.src = vq[i].src;
            bus.mask = vq[i].mask;
            bus.intr_ack = vq[i].ack;
            tick();
            check($sformatf("vec%0d_interrupt", i), 32'(bus.interrupt), 32'(vq[i].exp_int));
            check($sformatf("vec%0d_pending", i), 32'(bus.pending), 32'(vq[i].exp_pend));
            if (vq[i].exp_int)
                check($sformatf("vec%0d_id", i), 32'(bus.intr_id), 32'(vq[i].exp_id));
        end
        bus.intr_ack = 1'b0;

        // Timeout: unacknowledged interrupt is withdrawn after ACK_TMO cycles and retried.
        bus.src = '0;
        repeat (3) tick();
        bus.src = 4'b0001;
        n = 0;
        while (!bus.interrupt && n < 10) begin tick(); n++; end
        check("tmo_assert_seen", 32'(bus.interrupt), 32'd1);
        check("tmo_id", 32'(bus.intr_id), 32'd0);
        n = 0;
        while (bus.interrupt && n < 200) begin n++; tick(); end
        check("tmo_high_cycles", 32'(n), 32'(ACK_TMO));
        check("tmo_pending_held", 32'(bus.pending), 32'b0001);
        m = 0;
        while (!bus.interrupt && m < 50) begin m++; tick(); end
        check("tmo_low_cycles", 32'(m), 32'(GAP + 1));
        check("tmo_reassert", 32'(bus.interrupt), 32'd1);
        check("tmo_reassert_id", 32'(bus.intr_id), 32'd0);
        bus.intr_ack = 1'b1;
        tick();
        bus.intr_ack = 1'b0;
        check("tmo_ack_interrupt", 32'(bus.interrupt), 32'd0);
        check("tmo_ack_pending", 32'(bus.pending), 32'd0);

        // Asynchronous reset in the middle of an asserted interrupt.
        bus.src = '0;
        repeat (GAP + 2) tick();
        bus.src = 4'b0010;
        n = 0;
        while (!bus.interrupt && n < 10) begin tick(); n++; end
        check("rst_pre_interrupt", 32'(bus.interrupt), 32'd1);
        check("rst_pre_id", 32'(bus.intr_id), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("rst_async_interrupt", 32'(bus.interrupt), 32'd0);
        check("rst_async_id", 32'(bus.intr_id), 32'd0);
        check("rst_async_pending", 32'(bus.pending), 32'd0);
        bus.src = '0;
        @(negedge clk);
        rst = 1'b0;
        repeat (4) tick();
        check("rst_after_interrupt", 32'(bus.interrupt), 32'd0);
        check("rst_after_pending", 32'(bus.pending), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
